ucsbece154b_branch_resolve: RTL and testbench

Execute-side partner of the BTB/gshare predictor. It carries each fetched instruction's prediction metadata from F through D to E, compares it with the resolved outcome in E, and drives the predictor's update port: PHT write, BTB write and GHR reset. It also produces the misprediction flush/redirect for the hazard unit and keeps saturating branch statistics.

---
 rtl/ucsbece154b_branch_resolve_if.sv | 49 ++++
 rtl/ucsbece154b_branch_resolve.sv | 115 +++++++++++
 tb/tb_ucsbece154b_branch_resolve.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ucsbece154b_branch_resolve_if.sv
// Port bundle between the branch-resolve unit, the F/D/E pipeline controls
// and the BTB/gshare predictor update port.
interface ucsbece154b_branch_resolve_if #(
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int NUM_GHR_BITS    = 5
);
    logic [31:0]                        pc_f_i;
    logic                               predtaken_f_i;
    logic [31:0]                        predtarget_f_i;
    logic [NUM_GHR_BITS-1:0]            phtidx_f_i;
    logic                               stall_d_i;
    logic                               flush_d_i;
    logic                               flush_e_i;
    logic [6:0]                         op_e_i;
    logic                               taken_e_i;
    logic [31:0]                        target_e_i;

    logic                               PHTwe_o;
    logic                               PHTincrement_o;
    logic [NUM_GHR_BITS-1:0]            PHTwriteaddress_o;
    logic                               BTBwe_o;
    logic [$clog2(NUM_BTB_ENTRIES)-1:0] BTBwriteaddress_o;
    logic [31:0]                        BTBwritedata_o;
    logic                               GHRreset_o;
    logic                               mispredict_o;
    logic [31:0]                        redirect_pc_o;
    logic [31:0]                        branch_count_o;
    logic [31:0]                        mispredict_count_o;

    modport slave (
        input  pc_f_i, predtaken_f_i, predtarget_f_i, phtidx_f_i,
               stall_d_i, flush_d_i, flush_e_i,
               op_e_i, taken_e_i, target_e_i,
        output PHTwe_o, PHTincrement_o, PHTwriteaddress_o,
               BTBwe_o, BTBwriteaddress_o, BTBwritedata_o,
               GHRreset_o, mispredict_o, redirect_pc_o,
               branch_count_o, mispredict_count_o
    );

    modport master (
        output pc_f_i, predtaken_f_i, predtarget_f_i, phtidx_f_i,
               stall_d_i, flush_d_i, flush_e_i,
               op_e_i, taken_e_i, target_e_i,
        input  PHTwe_o, PHTincrement_o, PHTwriteaddress_o,
               BTBwe_o, BTBwriteaddress_o, BTBwritedata_o,
               GHRreset_o, mispredict_o, redirect_pc_o,
               branch_count_o, mispredict_count_o
    );
endinterface

// File: rtl/ucsbece154b_branch_resolve.sv
// Carries prediction metadata F->D->E, resolves it against the executed
// outcome and drives the predictor update, flush/redirect and statistics.
module ucsbece154b_branch_resolve #(
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int NUM_GHR_BITS    = 5
) (
    input  logic                         clk,
    input  logic                         reset_i,
    ucsbece154b_branch_resolve_if.slave  bus
);
    localparam int         IDX_W     = $clog2(NUM_BTB_ENTRIES);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic                    valid;
        logic [31:0]             pc;
        logic                    predtaken;
        logic [31:0]             predtarget;
        logic [NUM_GHR_BITS-1:0] phtidx;
    } meta_t;

    meta_t       dstage_q, dstage_d;
    meta_t       estage_q, estage_d;
    logic        started_q, started_d;
    logic        ghr_pulse_q, ghr_pulse_d;
    logic [31:0] branch_count_q, branch_count_d;
    logic [31:0] mispredict_count_q, mispredict_count_d;

    logic        is_br, is_j, target_miss, mispredict, pht_we, btb_we;
    logic [31:0] redirect_pc;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
        return (en && (value != 32'hFFFF_FFFF)) ? value + 32'd1 : value;
    endfunction

    // flush beats stall in D; a stalled D sends a bubble into E
    always_comb begin
        dstage_d = dstage_q;
        if (bus.flush_d_i) begin
            dstage_d.valid = 1'b0;
        end else if (!bus.stall_d_i) begin
            dstage_d.valid      = 1'b1;
            dstage_d.pc         = bus.pc_f_i;
            dstage_d.predtaken  = bus.predtaken_f_i;
            dstage_d.predtarget = bus.predtarget_f_i;
            dstage_d.phtidx     = bus.phtidx_f_i;
        end

        estage_d = estage_q;
        if (bus.flush_e_i) begin
            estage_d.valid = 1'b0;
        end else begin
            estage_d = dstage_q;
            if (bus.stall_d_i) estage_d.valid = 1'b0;
        end
    end

    always_comb begin
        is_br       = estage_q.valid && (bus.op_e_i == OP_BRANCH);
        is_j        = estage_q.valid && ((bus.op_e_i == OP_JAL) || (bus.op_e_i == OP_JALR));
        target_miss = (bus.target_e_i != estage_q.predtarget);

        if (is_br) begin
            mispredict = (bus.taken_e_i != estage_q.predtaken) || (bus.taken_e_i && target_miss);
        end else if (is_j) begin
            mispredict = !estage_q.predtaken || target_miss;
        end else begin
            // a BTB hit on a non-control instruction is an alias and must be undone
            mispredict = estage_q.valid && estage_q.predtaken;
        end

        pht_we      = is_br;
        btb_we      = (is_br || is_j) && bus.taken_e_i && (!estage_q.predtaken || target_miss);
        redirect_pc = ((is_br || is_j) && bus.taken_e_i) ? bus.target_e_i : estage_q.pc + 32'd4;

        started_d          = 1'b1;
        ghr_pulse_d        = !started_q;
        branch_count_d     = sat_inc(branch_count_q, pht_we);
        mispredict_count_d = sat_inc(mispredict_count_q, mispredict);
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            dstage_q           <= '0;
            estage_q           <= '0;
            started_q          <= 1'b0;
            ghr_pulse_q        <= 1'b0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            dstage_q           <= dstage_d;
            estage_q           <= estage_d;
            started_q          <= started_d;
            ghr_pulse_q        <= ghr_pulse_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    // E is cleared during reset, so only fields fed straight from inputs need masking
    assign bus.PHTwe_o            = pht_we;
    assign bus.PHTincrement_o     = bus.taken_e_i && !reset_i;
    assign bus.PHTwriteaddress_o  = estage_q.phtidx;
    assign bus.BTBwe_o            = btb_we;
    assign bus.BTBwriteaddress_o  = estage_q.pc[IDX_W+1:2];
    assign bus.BTBwritedata_o     = reset_i ? 32'd0 : bus.target_e_i;
    assign bus.GHRreset_o         = ghr_pulse_q;
    assign bus.mispredict_o       = mispredict;
    assign bus.redirect_pc_o      = reset_i ? 32'd0 : redirect_pc;
    assign bus.branch_count_o     = branch_count_q;
    assign bus.mispredict_count_o = mispredict_count_q;

endmodule

// File: tb/tb_ucsbece154b_branch_resolve.sv
// Bench for ucsbece154b_branch_resolve: directed vector table, hand-written
// pipeline sequences and random traffic against a slot-level reference model.
module tb_ucsbece154b_branch_resolve;
    localparam int NB = 32;
    localparam int NG = 5;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ALU  = 7'b0110011;

    logic clk = 1'b0;
    logic reset_i;
    always #5 clk = ~clk;

    ucsbece154b_branch_resolve_if #(.NUM_BTB_ENTRIES(NB), .NUM_GHR_BITS(NG)) bus ();
    ucsbece154b_branch_resolve #(.NUM_BTB_ENTRIES(NB), .NUM_GHR_BITS(NG)) dut (
        .clk     (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    typedef struct {
        bit          v;
        bit [31:0]   pc;
        bit          pt;
        bit [31:0]   ptg;
        bit [NG-1:0] idx;
    } slot_t;

    typedef struct {
        bit          mp;
        bit [31:0]   redir;
        bit          phtwe;
        bit          inc;
        bit [NG-1:0] paddr;
        bit          btbwe;
        bit [4:0]    baddr;
        bit [31:0]   bdata;
    } out_t;

    slot_t     md, me;
    bit [31:0] m_br, m_mp;
    int        edges_since_reset;

    function automatic out_t model_out();
        out_t o = '{default: 0};
        bit   br, j, tk;
        bit [31:0] tgt;
        if (reset_i) return o;
        tk  = bus.taken_e_i;
        tgt = bus.target_e_i;
        br  = me.v && (bus.op_e_i == OP_BR);
        j   = me.v && ((bus.op_e_i == OP_JAL) || (bus.op_e_i == OP_JALR));
        if (br)        o.mp = (tk != me.pt) || (tk && (tgt != me.ptg));
        else if (j)    o.mp = !me.pt || (tgt != me.ptg);
        else           o.mp = me.v && me.pt;
        o.redir = ((br || j) && tk) ? tgt : me.pc + 32'd4;
        o.phtwe = br;
        o.inc   = tk;
        o.paddr = me.idx;
        o.btbwe = (br || j) && tk && (!me.pt || (tgt != me.ptg));
        o.baddr = me.pc[6:2];
        o.bdata = tgt;
        return o;
    endfunction

    task automatic model_reset();
        md = '{default: 0};
        me = '{default: 0};
        m_br = 0;
        m_mp = 0;
        edges_since_reset = 0;
    endtask

    task automatic model_edge();
        out_t o;
        if (reset_i) begin
            model_reset();
            return;
        end
        o = model_out();
        if (o.phtwe && m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
        if (o.mp && m_mp != 32'hFFFF_FFFF) m_mp = m_mp + 1;
        if (edges_since_reset < 2) edges_since_reset++;
        if (bus.flush_e_i) me.v = 1'b0;
        else begin
            me = md;
            if (bus.stall_d_i) me.v = 1'b0;
        end
        if (bus.flush_d_i) md.v = 1'b0;
        else if (!bus.stall_d_i) begin
            md.v   = 1'b1;
            md.pc  = bus.pc_f_i;
            md.pt  = bus.predtaken_f_i;
            md.ptg = bus.predtarget_f_i;
            md.idx = bus.phtidx_f_i;
        end
    endtask

    // ---------------- checking ----------------
    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        out_t e = model_out();
        cmp({tag, " mispredict"}, bus.mispredict_o, e.mp);
        cmp({tag, " PHTwe"}, bus.PHTwe_o, e.phtwe);
        cmp({tag, " BTBwe"}, bus.BTBwe_o, e.btbwe);
        cmp({tag, " GHRreset"}, bus.GHRreset_o, !reset_i && edges_since_reset == 1);
        cmp({tag, " branch_count"}, bus.branch_count_o, m_br);
        cmp({tag, " mispredict_count"}, bus.mispredict_count_o, m_mp);
        if (e.mp) cmp({tag, " redirect"}, bus.redirect_pc_o, e.redir);
        if (e.phtwe) begin
            cmp({tag, " PHTincrement"}, bus.PHTincrement_o, e.inc);
            cmp({tag, " PHTaddr"}, bus.PHTwriteaddress_o, e.paddr);
        end
        if (e.btbwe) begin
            cmp({tag, " BTBaddr"}, bus.BTBwriteaddress_o, e.baddr);
            cmp({tag, " BTBdata"}, bus.BTBwritedata_o, e.bdata);
        end
    endtask

    task automatic check_all_zero(input string tag);
        cmp({tag, " PHTwe"}, bus.PHTwe_o, 0);
        cmp({tag, " PHTincrement"}, bus.PHTincrement_o, 0);
        cmp({tag, " PHTaddr"}, bus.PHTwriteaddress_o, 0);
        cmp({tag, " BTBwe"}, bus.BTBwe_o, 0);
        cmp({tag, " BTBaddr"}, bus.BTBwriteaddress_o, 0);
        cmp({tag, " BTBdata"}, bus.BTBwritedata_o, 0);
        cmp({tag, " GHRreset"}, bus.GHRreset_o, 0);
        cmp({tag, " mispredict"}, bus.mispredict_o, 0);
        cmp({tag, " redirect"}, bus.redirect_pc_o, 0);
        cmp({tag, " branch_count"}, bus.branch_count_o, 0);
        cmp({tag, " mispredict_count"}, bus.mispredict_count_o, 0);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_f(input bit [31:0] pc, input bit pt, input bit [31:0] ptg, input bit [NG-1:0] idx);
        bus.pc_f_i         = pc;
        bus.predtaken_f_i  = pt;
        bus.predtarget_f_i = ptg;
        bus.phtidx_f_i     = idx;
    endtask

    task automatic set_e(input bit [6:0] op, input bit tk, input bit [31:0] tgt);
        bus.op_e_i     = op;
        bus.taken_e_i  = tk;
        bus.target_e_i = tgt;
    endtask

    task automatic set_ctl(input bit st, input bit fd, input bit fe);
        bus.stall_d_i = st;
        bus.flush_d_i = fd;
        bus.flush_e_i = fe;
    endtask

    // called #1 after a falling edge; finishes the cycle on the next falling edge
    task automatic finish_cycle(input string tag);
        check_model(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic tick(input string tag);
        #1;
        finish_cycle(tag);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit [31:0] pc; bit pt; bit [31:0] ptg; bit [NG-1:0] idx;
        bit [6:0] op; bit tk; bit [31:0] tgt;
        bit mp; bit [31:0] redir; bit phtwe; bit inc; bit [NG-1:0] paddr;
        bit btbwe; bit [4:0] baddr; bit [31:0] bdata;
    } vec_t;

    localparam int NV = 11;
    vec_t      vt[NV];
    bit [31:0] pool[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          pc            pt ptg          idx op       tk tgt         mp redir        we inc addr btbwe baddr bdata
        vt[0]  = '{32'h40,        0, 32'h0,       5,  OP_BR,   1, 32'h80,     1, 32'h80,      1, 1, 5,   1,    16,   32'h80};
        vt[1]  = '{32'h40,        1, 32'h80,      5,  OP_BR,   0, 32'h80,     1, 32'h44,      1, 0, 5,   0,    0,    32'h0};
        vt[2]  = '{32'h10,        1, 32'h100,     3,  OP_JAL,  1, 32'h100,    0, 32'h100,     0, 0, 0,   0,    0,    32'h0};
        vt[3]  = '{32'h200,       1, 32'h240,     9,  OP_BR,   1, 32'h240,    0, 32'h240,     1, 1, 9,   0,    0,    32'h0};
        vt[4]  = '{32'h84,        1, 32'h300,     1,  OP_BR,   1, 32'h310,    1, 32'h310,     1, 1, 1,   1,    1,    32'h310};
        vt[5]  = '{32'h7C,        0, 32'h0,       2,  OP_JALR, 1, 32'h1000,   1, 32'h1000,    0, 0, 0,   1,    31,   32'h1000};
        vt[6]  = '{32'h20,        1, 32'h60,      4,  OP_ALU,  0, 32'h0,      1, 32'h24,      0, 0, 0,   0,    0,    32'h0};
        vt[7]  = '{32'h24,        0, 32'h0,       6,  OP_ALU,  0, 32'h0,      0, 32'h28,      0, 0, 0,   0,    0,    32'h0};
        vt[8]  = '{32'hFFFFFFFC,  1, 32'h8,       0,  OP_ALU,  0, 32'h0,      1, 32'h0,       0, 0, 0,   0,    0,    32'h0};
        vt[9]  = '{32'h30,        0, 32'h0,       31, OP_BR,   0, 32'h50,     0, 32'h34,      1, 0, 31,  0,    0,    32'h0};
        vt[10] = '{32'h90,        1, 32'h500,     0,  OP_JAL,  1, 32'h600,    1, 32'h600,     0, 0, 0,   1,    4,    32'h600};
        pool = '{32'h100, 32'h200, 32'h300, 32'h400};

        model_reset();
        reset_i = 1'b1;
        set_f(0, 0, 0, 0);
        set_e(OP_ALU, 0, 0);
        set_ctl(0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        // drive an E outcome that would be visible if reset did not mask it
        set_e(OP_BR, 1, 32'h1234);
        #1;
        check_all_zero("in_reset");
        @(negedge clk);

        // release and watch the one-cycle GHR clear
        reset_i = 1'b0;
        set_e(OP_ALU, 0, 0);
        #1;
        cmp("ghr before first edge", bus.GHRreset_o, 0);
        finish_cycle("release0");
        #1;
        cmp("ghr pulse", bus.GHRreset_o, 1);
        finish_cycle("release1");
        #1;
        cmp("ghr after pulse", bus.GHRreset_o, 0);
        finish_cycle("release2");

        // table: fetch, let it travel to E, then resolve
        for (int i = 0; i < NV; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            set_f(vt[i].pc, vt[i].pt, vt[i].ptg, vt[i].idx);
            set_e(OP_ALU, 0, 0);
            tick({tag, " fetch"});
            set_f(0, 0, 0, 0);
            tick({tag, " decode"});
            set_e(vt[i].op, vt[i].tk, vt[i].tgt);
            #1;
            cmp({tag, " mispredict"}, bus.mispredict_o, vt[i].mp);
            if (vt[i].mp) cmp({tag, " redirect"}, bus.redirect_pc_o, vt[i].redir);
            cmp({tag, " PHTwe"}, bus.PHTwe_o, vt[i].phtwe);
            if (vt[i].phtwe) begin
                cmp({tag, " PHTincrement"}, bus.PHTincrement_o, vt[i].inc);
                cmp({tag, " PHTaddr"}, bus.PHTwriteaddress_o, vt[i].paddr);
            end
            cmp({tag, " BTBwe"}, bus.BTBwe_o, vt[i].btbwe);
            if (vt[i].btbwe) begin
                cmp({tag, " BTBaddr"}, bus.BTBwriteaddress_o, vt[i].baddr);
                cmp({tag, " BTBdata"}, bus.BTBwritedata_o, vt[i].bdata);
            end
            finish_cycle({tag, " execute"});
            set_e(OP_ALU, 0, 0);
        end
        // 5 branches in the table; 7 mispredicting rows
        cmp("table branch_count", bus.branch_count_o, 5);
        cmp("table mispredict_count", bus.mispredict_count_o, 7);

        // stall D for two cycles, then flush a predicted-taken add out of fetch
        set_f(32'h104, 0, 0, 7);
        tick("stall fetch");
        set_ctl(1, 0, 0);
        set_f(32'h999C, 1, 32'h88, 30);
        tick("stall1");
        set_e(OP_BR, 1, 32'h140);
        #1;
        cmp("stall bubble mispredict", bus.mispredict_o, 0);
        cmp("stall bubble PHTwe", bus.PHTwe_o, 0);
        finish_cycle("stall2");
        set_ctl(0, 1, 0);
        set_f(32'h200, 1, 32'h208, 13);
        #1;
        cmp("stall bubble2 mispredict", bus.mispredict_o, 0);
        cmp("stall bubble2 PHTwe", bus.PHTwe_o, 0);
        finish_cycle("flush_d");
        set_ctl(0, 0, 0);
        set_f(0, 0, 0, 0);
        #1;
        cmp("held D mispredict", bus.mispredict_o, 1);
        cmp("held D redirect", bus.redirect_pc_o, 32'h140);
        cmp("held D PHTaddr", bus.PHTwriteaddress_o, 7);
        cmp("held D BTBaddr", bus.BTBwriteaddress_o, 1);
        finish_cycle("held D");
        set_e(OP_ALU, 0, 0);
        #1;
        cmp("flushed add mispredict", bus.mispredict_o, 0);
        finish_cycle("flushed add");

        // flush_e with a valid E still reports this cycle's outcome
        set_f(32'h300, 0, 0, 11);
        tick("fe fetch");
        set_f(32'h304, 1, 32'h400, 12);
        tick("fe decode");
        set_f(0, 0, 0, 0);
        set_ctl(0, 0, 1);
        set_e(OP_BR, 1, 32'h340);
        #1;
        cmp("flush_e mispredict", bus.mispredict_o, 1);
        cmp("flush_e PHTwe", bus.PHTwe_o, 1);
        finish_cycle("flush_e");
        set_ctl(0, 0, 0);
        set_e(OP_ALU, 0, 0);
        #1;
        cmp("after flush_e mispredict", bus.mispredict_o, 0);
        finish_cycle("after flush_e");

        // reset arriving mid-pipeline discards in-flight metadata
        set_f(32'h500, 0, 0, 12);
        tick("rst fetch");
        set_f(32'h504, 1, 32'h900, 3);
        #1;
        reset_i = 1'b1;
        #1;
        check_all_zero("mid reset");
        @(posedge clk);
        model_edge();
        @(negedge clk);
        reset_i = 1'b0;
        set_f(0, 0, 0, 0);
        set_e(OP_BR, 1, 32'h540);
        #1;
        cmp("post reset PHTwe", bus.PHTwe_o, 0);
        cmp("post reset mispredict", bus.mispredict_o, 0);
        finish_cycle("post reset0");
        set_e(OP_ALU, 0, 0);
        #1;
        cmp("post reset ghr pulse", bus.GHRreset_o, 1);
        cmp("post reset mispredict2", bus.mispredict_o, 0);
        finish_cycle("post reset1");

        // mispredict counter saturation
        set_f(32'h600, 1, 32'h700, 0);
        tick("sat fill0");
        tick("sat fill1");
        force dut.mispredict_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.mispredict_count_q;
        m_mp = 32'hFFFF_FFFE;
        finish_cycle("sat0");
        tick("sat1");
        tick("sat2");
        #1;
        cmp("saturated mispredict_count", bus.mispredict_count_o, 32'hFFFF_FFFF);
        finish_cycle("sat3");

        // random traffic against the model
        for (int k = 0; k < 600; k++) begin
            int sel;
            sel = $urandom_range(0, 3);
            set_ctl($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            set_f($urandom & 32'h0000_0FFC, $urandom_range(0, 1), pool[$urandom_range(0, 3)], NG'($urandom_range(0, 31)));
            case (sel)
                0:       bus.op_e_i = OP_BR;
                1:       bus.op_e_i = OP_JAL;
                2:       bus.op_e_i = OP_JALR;
                default: bus.op_e_i = OP_ALU;
            endcase
            bus.taken_e_i  = (sel == 1 || sel == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.target_e_i = $urandom_range(0, 1) ? me.ptg : pool[$urandom_range(0, 3)];
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
